// File: rtl/mdio_arbiter_if.sv
// rtl/mdio_arbiter_if.sv - client request/response and MDIO generator signals of mdio_arbiter
interface mdio_arbiter_if;
  logic        req0_valid;
  logic        req0_write;
  logic [4:0]  req0_phy;
  logic [4:0]  req0_reg;
  logic [15:0] req0_wdata;
  logic        req0_ready;
  logic        req1_valid;
  logic        req1_write;
  logic [4:0]  req1_phy;
  logic [4:0]  req1_reg;
  logic [15:0] req1_wdata;
  logic        req1_ready;
  logic        rsp0_valid;
  logic [15:0] rsp0_rdata;
  logic        rsp1_valid;
  logic [15:0] rsp1_rdata;
  logic        mdio_start;
  logic [31:0] t_data;
  logic [15:0] gen_rd_data;
  logic        busy;

  modport slave (
    input  req0_valid, req0_write, req0_phy, req0_reg, req0_wdata,
    input  req1_valid, req1_write, req1_phy, req1_reg, req1_wdata,
    input  gen_rd_data,
    output req0_ready, req1_ready, rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    output mdio_start, t_data, busy
  );

  modport master (
    output req0_valid, req0_write, req0_phy, req0_reg, req0_wdata,
    output req1_valid, req1_write, req1_phy, req1_reg, req1_wdata,
    output gen_rd_data,
    input  req0_ready, req1_ready, rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    input  mdio_start, t_data, busy
  );
endinterface

// File: rtl/mdio_arbiter.sv
// rtl/mdio_arbiter.sv - two-client Clause-22 arbiter/sequencer for generador_mdio
// MDIO_ARB_ROUND_ROBIN_EN selects round-robin grant; default is fixed priority to client 0.
module mdio_arbiter #(
  parameter int unsigned FRAME_CLKS = 132,
  parameter int unsigned START_CLKS = 4
) (
  input logic          clk,
  input logic          reset,
  mdio_arbiter_if.slave bus
);
  localparam int unsigned CW = $clog2(FRAME_CLKS);
  localparam logic [CW-1:0] LAST_C  = CW'(FRAME_CLKS - 1);
  localparam logic [CW-1:0] START_C = CW'(START_CLKS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          gnt_q, gnt_d;
  logic          wr_q, wr_d;
  logic [31:0]   t_data_q, t_data_d;
  logic [15:0]   rdata0_q, rdata0_d;
  logic [15:0]   rdata1_q, rdata1_d;
  logic          sel;
  logic          ready0, ready1;

  function automatic logic [31:0] build_frame(input logic wr, input logic [4:0] phy,
                                              input logic [4:0] reg_a, input logic [15:0] wd);
    return {2'b01, (wr ? 2'b01 : 2'b10), phy, reg_a, (wr ? 2'b10 : 2'b00), (wr ? wd : 16'h0000)};
  endfunction

  always_comb begin
    sel = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
`ifdef MDIO_ARB_ROUND_ROBIN_EN
      sel = ~last_q;
`else
      sel = 1'b0;
`endif
    end else if (bus.req1_valid) begin
      sel = 1'b1;
    end
  end

  // Ready is withheld during reset so nothing can be accepted on the reset edge.
  assign ready0 = (state_q == IDLE) && !reset && bus.req0_valid && !sel;
  assign ready1 = (state_q == IDLE) && !reset && bus.req1_valid && sel;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    wr_d     = wr_q;
    t_data_d = t_data_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (ready0 || ready1) begin
          state_d  = BUSY;
          cnt_d    = '0;
          last_d   = sel;
          gnt_d    = sel;
          wr_d     = sel ? bus.req1_write : bus.req0_write;
          t_data_d = sel ? build_frame(bus.req1_write, bus.req1_phy, bus.req1_reg, bus.req1_wdata)
                         : build_frame(bus.req0_write, bus.req0_phy, bus.req0_reg, bus.req0_wdata);
        end
      end
      BUSY: begin
        if (cnt_q == LAST_C) begin
          state_d = RESP;
          if (!wr_q) begin
            if (gnt_q) rdata1_d = bus.gen_rd_data;
            else       rdata0_d = bus.gen_rd_data;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      wr_q     <= 1'b0;
      t_data_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      wr_q     <= wr_d;
      t_data_q <= t_data_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp0_valid = (state_q == RESP) && !gnt_q;
  assign bus.rsp1_valid = (state_q == RESP) && gnt_q;
  assign bus.rsp0_rdata = rdata0_q;
  assign bus.rsp1_rdata = rdata1_q;
  assign bus.mdio_start = (state_q == BUSY) && (cnt_q < START_C);
  assign bus.t_data     = t_data_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_mdio_arbiter.sv
// tb/tb_mdio_arbiter.sv - scoreboard testbench for mdio_arbiter
`timescale 1ns/1ps
module tb_mdio_arbiter;
  localparam int F = 132;
  localparam int S = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mdio_arbiter_if bus();
  mdio_arbiter #(.FRAME_CLKS(F), .START_CLKS(S)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic        v[2];
  logic        w[2];
  logic [4:0]  phy[2];
  logic [4:0]  rg[2];
  logic [15:0] wd[2];
  logic [15:0] gen;

  assign bus.req0_valid  = v[0];
  assign bus.req0_write  = w[0];
  assign bus.req0_phy    = phy[0];
  assign bus.req0_reg    = rg[0];
  assign bus.req0_wdata  = wd[0];
  assign bus.req1_valid  = v[1];
  assign bus.req1_write  = w[1];
  assign bus.req1_phy    = phy[1];
  assign bus.req1_reg    = rg[1];
  assign bus.req1_wdata  = wd[1];
  assign bus.gen_rd_data = gen;

  typedef struct {
    int          client;
    logic [31:0] frame;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] rd_model[2];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [31:0] frame_of(input int i);
    logic [1:0] op;
    logic [1:0] ta;
    logic [15:0] d;
    op = w[i] ? 2'b01 : 2'b10;
    ta = w[i] ? 2'b10 : 2'b00;
    d  = w[i] ? wd[i] : 16'h0000;
    return {2'b01, op, phy[i], rg[i], ta, d};
  endfunction

  function automatic logic rsp_of(input int i);
    return (i == 0) ? bus.rsp0_valid : bus.rsp1_valid;
  endfunction

  function automatic logic [15:0] rdata_of(input int i);
    return (i == 0) ? bus.rsp0_rdata : bus.rsp1_rdata;
  endfunction

  task automatic set_req(input int i, input logic wr, input logic [4:0] p, input logic [4:0] r,
                         input logic [15:0] d);
    w[i] = wr; phy[i] = p; rg[i] = r; wd[i] = d;
  endtask

  task automatic wait_handshake(input logic [15:0] gen_val, output int who, output int waited);
    who = -1;
    waited = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.req0_ready && bus.req1_ready) begin
        n_bad++;
        $display("FAIL both_ready: req0_ready=%b req1_ready=%b, required not both 1", bus.req0_ready, bus.req1_ready);
      end
      if (v[0] && bus.req0_ready) who = 0;
      else if (v[1] && bus.req1_ready) who = 1;
      if (who >= 0) begin
        sb.push_back('{who, frame_of(who), (w[who] ? rd_model[who] : gen_val)});
        break;
      end
      waited++;
    end
    if (who < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL handshake_timeout: no handshake in 400 cycles, required one");
    end
  endtask

  task automatic follow_frame(input int who, input logic [15:0] gen_val, input bit drop_valid,
                              input bit perturb, input bit raise_other);
    exp_t e;
    e = sb[0];
    for (int k = 1; k <= F + 1; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b1) begin
        n_bad++; $display("FAIL busy k=%0d: got %b, required 1", k, bus.busy);
      end
      n_cmp++;
      if ((bus.req0_ready | bus.req1_ready) !== 1'b0) begin
        n_bad++; $display("FAIL ready_in_busy k=%0d: got %b/%b, required 0/0", k, bus.req0_ready, bus.req1_ready);
      end
      if (k <= F) begin
        n_cmp++;
        if (bus.t_data !== e.frame) begin
          n_bad++; $display("FAIL t_data k=%0d: got %h, required %h", k, bus.t_data, e.frame);
        end
        n_cmp++;
        if (bus.mdio_start !== 1'(k <= S)) begin
          n_bad++; $display("FAIL mdio_start k=%0d: got %b, required %b", k, bus.mdio_start, (k <= S));
        end
        n_cmp++;
        if ((bus.rsp0_valid | bus.rsp1_valid) !== 1'b0) begin
          n_bad++; $display("FAIL early_rsp k=%0d: got %b/%b, required 0/0", k, bus.rsp0_valid, bus.rsp1_valid);
        end
      end else begin
        n_cmp++;
        if (bus.mdio_start !== 1'b0) begin
          n_bad++; $display("FAIL mdio_start_resp: got %b, required 0", bus.mdio_start);
        end
        n_cmp++;
        if (rsp_of(who) !== 1'b1) begin
          n_bad++; $display("FAIL rsp%0d_valid: got %b, required 1", who, rsp_of(who));
        end
        n_cmp++;
        if (rsp_of(1 - who) !== 1'b0) begin
          n_bad++; $display("FAIL rsp%0d_valid_other: got %b, required 0", 1 - who, rsp_of(1 - who));
        end
        e = sb.pop_front();
        n_cmp++;
        if (who !== e.client) begin
          n_bad++; $display("FAIL rsp_client: got %0d, required %0d", who, e.client);
        end
        rd_model[who] = e.rdata;
        n_cmp++;
        if (rdata_of(who) !== rd_model[who]) begin
          n_bad++; $display("FAIL rsp%0d_rdata: got %h, required %h", who, rdata_of(who), rd_model[who]);
        end
        n_cmp++;
        if (rdata_of(1 - who) !== rd_model[1 - who]) begin
          n_bad++; $display("FAIL rsp%0d_rdata_other: got %h, required %h", 1 - who, rdata_of(1 - who), rd_model[1 - who]);
        end
      end
      if (k == 1 && drop_valid) v[who] = 1'b0;
      if (k == 10 && perturb) begin
        phy[who] = ~phy[who]; rg[who] = ~rg[who]; wd[who] = ~wd[who]; w[who] = ~w[who];
      end
      if (k == 20 && raise_other) v[1 - who] = 1'b1;
      gen = (k == F) ? gen_val : 16'hDEAD;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    v[0] = 1'b0; v[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    rd_model[0] = '0; rd_model[1] = '0;
  endtask

  task automatic test_reset();
    v[0] = 1'b1; v[1] = 1'b1;
    set_req(0, 1'b1, 5'd1, 5'd1, 16'h1111);
    set_req(1, 1'b0, 5'd2, 5'd2, 16'h2222);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.req0_ready, bus.req1_ready, bus.busy, bus.mdio_start, bus.rsp0_valid, bus.rsp1_valid} !== 6'b0) begin
        n_bad++; $display("FAIL reset_ctrl: rdy=%b%b busy=%b start=%b rsp=%b%b, required all 0",
                          bus.req0_ready, bus.req1_ready, bus.busy, bus.mdio_start, bus.rsp0_valid, bus.rsp1_valid);
      end
      n_cmp++;
      if ({bus.t_data, bus.rsp0_rdata, bus.rsp1_rdata} !== 64'h0) begin
        n_bad++; $display("FAIL reset_data: t_data=%h rdata0=%h rdata1=%h, required 0", bus.t_data, bus.rsp0_rdata, bus.rsp1_rdata);
      end
    end
    v[0] = 1'b0; v[1] = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.req0_ready, bus.req1_ready, bus.busy, bus.mdio_start, bus.rsp0_valid, bus.rsp1_valid} !== 6'b0) begin
        n_bad++; $display("FAIL idle_static: rdy=%b%b busy=%b start=%b rsp=%b%b, required all 0",
                          bus.req0_ready, bus.req1_ready, bus.busy, bus.mdio_start, bus.rsp0_valid, bus.rsp1_valid);
      end
    end
  endtask

  task automatic test_write_client0();
    int who, waited;
    set_req(0, 1'b1, 5'd1, 5'd4, 16'hABCD);
    v[0] = 1'b1;
    wait_handshake(16'hDEAD, who, waited);
    if (who < 0) return;
    follow_frame(who, 16'hDEAD, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (bus.t_data !== 32'h5092ABCD) begin
      n_bad++; $display("FAIL write_frame: got %h, required 5092abcd", bus.t_data);
    end
  endtask

  task automatic test_read_client1();
    int who, waited;
    set_req(1, 1'b0, 5'd3, 5'd1, 16'hFFFF);
    v[1] = 1'b1;
    wait_handshake(16'h1234, who, waited);
    if (who < 0) return;
    follow_frame(who, 16'h1234, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (bus.t_data !== 32'h61840000 || bus.rsp1_rdata !== 16'h1234) begin
      n_bad++; $display("FAIL read_frame: t_data=%h rdata1=%h, required 61840000/1234", bus.t_data, bus.rsp1_rdata);
    end
  endtask

  task automatic test_simultaneous();
    int who, waited;
`ifdef MDIO_ARB_ROUND_ROBIN_EN
    int order[$] = '{0, 1, 0, 1};
`else
    int order[$] = '{0, 0, 0};
`endif
    apply_reset();
    set_req(0, 1'b1, 5'd2, 5'd5, 16'h1111);
    set_req(1, 1'b0, 5'd6, 5'd7, 16'h0000);
    v[0] = 1'b1; v[1] = 1'b1;
    foreach (order[i]) begin
      wait_handshake(16'h5A00 + 16'(i), who, waited);
      if (who < 0) break;
      n_cmp++;
      if (who !== order[i]) begin
        n_bad++; $display("FAIL grant_order[%0d]: got client %0d, required %0d", i, who, order[i]);
      end
      follow_frame(who, 16'h5A00 + 16'(i), 1'b0, 1'b0, 1'b0);
    end
    v[0] = 1'b0; v[1] = 1'b0;
  endtask

  task automatic test_change_fields();
    int who, waited;
    set_req(0, 1'b0, 5'd9, 5'd2, 16'h0000);
    v[0] = 1'b1;
    wait_handshake(16'hBEEF, who, waited);
    if (who < 0) return;
    follow_frame(who, 16'hBEEF, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_busy();
    int who, waited;
    set_req(1, 1'b1, 5'd4, 5'd3, 16'h0F0F);
    v[1] = 1'b1;
    wait_handshake(16'hDEAD, who, waited);
    if (who < 0) return;
    for (int k = 1; k <= 51; k++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.mdio_start, bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready} !== 6'b0) begin
      n_bad++; $display("FAIL midreset_ctrl: busy=%b start=%b rsp=%b%b rdy=%b%b, required all 0",
                        bus.busy, bus.mdio_start, bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready);
    end
    n_cmp++;
    if ({bus.t_data, bus.rsp0_rdata, bus.rsp1_rdata} !== 64'h0) begin
      n_bad++; $display("FAIL midreset_data: t_data=%h rdata0=%h rdata1=%h, required 0", bus.t_data, bus.rsp0_rdata, bus.rsp1_rdata);
    end
    reset = 1'b0;
    v[1] = 1'b0;
    sb.delete();
    rd_model[0] = '0; rd_model[1] = '0;
    for (int c = 0; c < 140; c++) begin
      @(negedge clk);
      n_cmp++;
      if ((bus.rsp0_valid | bus.rsp1_valid | bus.busy) !== 1'b0) begin
        n_bad++; $display("FAIL midreset_quiet c=%0d: rsp=%b%b busy=%b, required 0", c, bus.rsp0_valid, bus.rsp1_valid, bus.busy);
      end
    end
    set_req(1, 1'b0, 5'd1, 5'd1, 16'h0000);
    v[1] = 1'b1;
    wait_handshake(16'h7777, who, waited);
    if (who < 0) return;
    follow_frame(who, 16'h7777, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int who, waited;
    set_req(0, 1'b1, 5'd5, 5'd6, 16'h2222);
    set_req(1, 1'b0, 5'd7, 5'd8, 16'h0000);
    v[0] = 1'b1;
    wait_handshake(16'hDEAD, who, waited);
    if (who < 0) return;
    follow_frame(who, 16'hDEAD, 1'b1, 1'b0, 1'b1);
    wait_handshake(16'h4321, who, waited);
    if (who < 0) return;
    n_cmp++;
    if (who !== 1 || waited !== 0) begin
      n_bad++; $display("FAIL back_to_back: client %0d after %0d idle cycles, required client 1 after 0", who, waited);
    end
    follow_frame(who, 16'h4321, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    v[0] = 1'b0; v[1] = 1'b0;
    gen = 16'hDEAD;
    rd_model[0] = '0; rd_model[1] = '0;
    test_reset();
    test_write_client0();
    test_read_client1();
    test_simultaneous();
    test_change_fields();
    test_reset_mid_busy();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mdio_arbiter.md
# mdio_arbiter

Two-port transaction arbiter and sequencer in front of the `generador_mdio` MDIO master. It accepts Clause-22 register read/write requests from two independent clients and grants one at a time. It builds the 32-bit management frame, drives `mdio_start`/`t_data` to the generator for a fixed frame window, then returns read data or write completion to the granted client.

## Interface
- `FRAME_CLKS`, default 132: clk cycles per transaction, counted from `mdio_start` assertion; minimum 8.
- `START_CLKS`, default 4: cycles `mdio_start` is held high, one MDC period at clk/4.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high. Clock is `clk`.
- `reqN_valid` in 1 (N=0,1): client N request valid.
- `reqN_write` in 1: 1 = write, 0 = read.
- `reqN_phy` in 5: PHY address.
- `reqN_reg` in 5: register address.
- `reqN_wdata` in 16: write data; ignored for reads.
- `reqN_ready` out 1: request accepted when `reqN_valid & reqN_ready`.
- `rspN_valid` out 1: one-cycle completion pulse to client N.
- `rspN_rdata` out 16: read data, held until the next response to N.
- `mdio_start` out 1: to generator.
- `t_data` out 32: frame to generator.
- `gen_rd_data` in 16: generator read data.
- `busy` out 1: high from acceptance until the response cycle, inclusive.

## Operation
- States:
  - IDLE: `reqN_ready` high only for the client selected by the arbiter this cycle; never both.
  - BUSY
  - RESP
- IDLE→BUSY on handshake; frame latched into `t_data` on the handshake edge. `cnt` is cleared.
- BUSY:
  - `cnt` increments 0..FRAME_CLKS-1.
  - `mdio_start` = 1 while `cnt` < START_CLKS.
  - `t_data` is stable throughout.
  - At `cnt` == FRAME_CLKS-1: for a read, `gen_rd_data` is captured into the granted `rspN_rdata`; then go to RESP.
- RESP: `rspN_valid` = 1 for the granted N only, for one cycle; `rspN_rdata` for a write is left unchanged. Then →IDLE.
- Frame, MSB first:
  - [31:30] ST = 01
  - [29:28] OP = 01 write / 10 read
  - [27:23] phy
  - [22:18] reg
  - [17:16] TA = 10 write / 00 read
  - [15:0] wdata write / 0x0000 read
- Grant pointer `last` updates on each handshake to the accepted client.
- Request inputs are sampled only at the handshake. Later changes do not affect the in-flight frame.
- A client may hold `valid` during another client's transaction; it waits.

## Timing
- Handshake in cycle T:
  - BUSY covers T+1..T+FRAME_CLKS.
  - `mdio_start` is high T+1..T+START_CLKS.
  - `rspN_valid` is high at T+FRAME_CLKS+1.
  - Earliest next handshake is T+FRAME_CLKS+2.
- Reset values:
  - state IDLE
  - `reqN_ready` 0 in the reset cycle
  - `rspN_valid` 0
  - `rspN_rdata` 0x0000
  - `mdio_start` 0
  - `t_data` 0x00000000
  - `busy` 0
  - `cnt` 0
  - `last` = 1, so client 0 wins the first tie
- Reset mid-BUSY: abort immediately. No `rsp` pulse; outputs take reset values on the next cycle.
- No requests: stay in IDLE, outputs static.

## Configuration
- `MDIO_ARB_ROUND_ROBIN_EN` defined: on simultaneous valid, grant the client ≠ `last`. With a single valid, grant it.
- Not defined: fixed priority, client 0 always wins; `last` is still tracked but unused for selection.

## Test plan
- Write, client 0:
  - Stimulus: `req0` write, phy 1, reg 4, data 0xABCD.
  - Required: `t_data` = 0x5092ABCD for 132 cycles; `mdio_start` high 4 cycles; `rsp0_valid` pulse at T+133; `rsp0_rdata` unchanged.
- Read, client 1:
  - Stimulus: `req1` read, phy 3, reg 1; `gen_rd_data` = 0x1234 at capture.
  - Required: `t_data` = 0x61840000; `rsp1_rdata` = 0x1234 with `rsp1_valid` at T+133; `rsp0_valid` stays 0.
- Simultaneous valid after reset, both held:
  - With RR: order is 0,1,0,1.
  - Without RR: 0,0,0; `req1_ready` never high.
- Request fields changed mid-BUSY: `t_data` unchanged.
- Reset asserted at `cnt` = 50: next cycle `busy`=0, `t_data`=0, `mdio_start`=0, no `rsp` pulse; a new request completes normally.
- Back-to-back: second handshake exactly at T+134. Check `busy` continuity and `ready` never high during BUSY/RESP.
